i2s_frame_ctrl: RTL and testbench
=================================

Name: i2s_frame_ctrl

Overview:
- Upstream neighbour of the 32-bit I2S parallel-load shift register (ports SCLK, LD, Din[31:0], s).
- Runs on the system clock and divides it down to generate SCLK and LRCLK.
- Accepts stereo samples over a valid/ready handshake.
- Presents each channel word, with a one-SCLK-period LD pulse, so the shifter loads on the correct SCLK rising edge in standard I2S framing: 64 SCLK per frame, left slot first, MSB one bit after each LRCLK edge.

Parameters:
- CLK_DIV, 8, number of Clk cycles per SCLK half-period; legal range 2 to 255. Default gives 50 MHz / 16 = 3.125 MHz SCLK, about 48.8 kHz frame rate.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- sample_valid  in  1  sample_left/right hold a new stereo sample
- sample_left  in  32  left-channel word, MSB first on the wire
- sample_right  in  32  right-channel word
- sample_ready  out  1  one-Clk pulse: sample consumed this cycle
- SCLK  out  1  I2S bit clock to the shifter and codec
- LRCLK  out  1  word select: 0 = left, 1 = right
- LD  out  1  load strobe to the shifter, sampled on SCLK rising edge
- Dout  out  32  word to the shifter Din
- underrun  out  1  sticky flag: a frame started with no valid sample
- underrun_clr  in  1  clears underrun

Behaviour:
- Clocking: one clock, Clk. Reset is synchronous and active-high. All state updates on posedge Clk.
- Reset values:
  - SCLK=0, LRCLK=1, LD=0, Dout=0, sample_ready=0, underrun=0
  - divider count=0, bit_cnt=62, right buffer=0
- Divider:
  - Count runs 0..CLK_DIV-1. At CLK_DIV-1 it wraps and SCLK toggles.
  - Toggle 0->1 is a rise event; toggle 1->0 is a fall event. Each event lasts one Clk.
- bit_cnt (6 bits):
  - Increments on each rise event and wraps 63->0.
  - bit_cnt[5] is the slot currently on the wire.
- On a fall event with bit_cnt==63 (left load):
  - LRCLK<=0, LD<=1.
  - If sample_valid: Dout<=sample_left, right buffer<=sample_right, sample_ready pulses high for that Clk.
  - Else: Dout<=0, right buffer<=0, underrun<=1, sample_ready stays 0.
- On a fall event with bit_cnt==31 (right load): LRCLK<=1, LD<=1, Dout<=right buffer. No handshake.
- On any other fall event: LD<=0. Dout and LRCLK hold.
- Result: the LRCLK edge coincides with the last bit of the previous word. The shifter loads on the following rise, so the MSB is delayed one SCLK after the LRCLK edge (I2S alignment).
- First frame after reset:
  - Rise at Clk CLK_DIV moves bit_cnt 62->63.
  - Fall at 2*CLK_DIV performs the left load.
  - Rise at 3*CLK_DIV latches the word in the shifter and bit_cnt becomes 0.
- sample_valid handling: sampled only in the left-load Clk cycle. Inputs outside that cycle are ignored. Upstream must hold valid/data until ready.
- underrun priority: set beats underrun_clr in the same cycle. Otherwise underrun_clr clears the flag next Clk.
- Reset mid-frame: every output returns to its reset value at the next Clk edge. An unconsumed sample is not acknowledged, and the partial frame is abandoned.
- Widths: Dout is always a full 32-bit word. No truncation or sign handling in this block.

Decomposition:
- Package i2s_pkg:
  - WORD_BITS=32, FRAME_BITS=64
  - LOAD_LEFT_IDX=63, LOAD_RIGHT_IDX=31
  - typedef enum {SLOT_LEFT=0, SLOT_RIGHT=1} i2s_slot_t
- Sub-module i2s_sclk_div:
  - Contains the divider counter, SCLK register, and rise/fall strobes.
  - Parameter CLK_DIV; ports Clk, Reset, SCLK, rise, fall.
- The frame controller instantiates i2s_sclk_div and holds bit_cnt, the load logic, the right buffer and the underrun flag.

Test Plan:
- CLK_DIV=2, Reset, sample_valid=1, left=32'hA5A5_0001, right=32'h5A5A_0002 -> first LD=1 and LRCLK 1->0 at Clk 4; sample_ready one pulse at Clk 4; shifter model outputs left MSB-first starting at Clk 6; right word's MSB appears 32 SCLK later with LRCLK=1 one SCLK earlier.
- Steady stream of 4 frames, CLK_DIV=2 -> exactly one sample_ready per 256 Clk; LD high for exactly CLK_DIV*2 Clk twice per frame; LRCLK period 64 SCLK, 50% duty.
- sample_valid=0 at a left-load -> Dout=0 loaded for both slots, underrun=1; assert underrun_clr together with another underrun frame -> underrun stays 1; clr in a clean frame -> 0.
- Change sample_left while sample_valid=0 between load points -> no sample_ready pulse and no Dout change except at the load events.
- Assert Reset at bit_cnt==40 -> next Clk: SCLK=0, LRCLK=1, LD=0, Dout=0; re-synchronised first load occurs at Clk 2*CLK_DIV after Reset release.
- CLK_DIV=255 -> SCLK half-period measured as 255 Clk; frame length 32640 Clk.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S frame controller.
// Frame is 64 SCLK: left slot then right slot, 32 bits each.
package i2s_pkg;

    localparam int WORD_BITS      = 32;
    localparam int FRAME_BITS     = 64;
    localparam int CNT_BITS       = $clog2(FRAME_BITS);
    localparam int LOAD_LEFT_IDX  = 63;
    localparam int LOAD_RIGHT_IDX = 31;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } i2s_slot_t;

endpackage

// File: rtl/i2s_sclk_div.sv
// Divides Clk down to SCLK and flags the Clk cycle before each
// SCLK edge as a one-cycle rise or fall strobe.
module i2s_sclk_div #(
    parameter int CLK_DIV = 8
) (
    input  logic Clk,
    input  logic Reset,
    output logic SCLK,
    output logic rise,
    output logic fall
);

    logic [7:0] cnt;
    logic       wrap;

    assign wrap = (cnt == 8'(CLK_DIV - 1));
    assign rise = wrap && !SCLK && !Reset;
    assign fall = wrap && SCLK && !Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt  <= '0;
            SCLK <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            SCLK <= ~SCLK;
        end else begin
            cnt  <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/i2s_frame_ctrl.sv
// I2S frame controller: generates SCLK/LRCLK and feeds the
// parallel-load shifter one word per slot with an LD strobe.
module i2s_frame_ctrl
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 sample_valid,
    input  logic [WORD_BITS-1:0] sample_left,
    input  logic [WORD_BITS-1:0] sample_right,
    output logic                 sample_ready,
    output logic                 SCLK,
    output logic                 LRCLK,
    output logic                 LD,
    output logic [WORD_BITS-1:0] Dout,
    output logic                 underrun,
    input  logic                 underrun_clr
);

    logic                 rise;
    logic                 fall;
    logic [CNT_BITS-1:0]  bit_cnt;
    logic [WORD_BITS-1:0] rbuf;
    i2s_slot_t            slot;
    logic                 left_ld;
    logic                 right_ld;

    i2s_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .Clk   (Clk),
        .Reset (Reset),
        .SCLK  (SCLK),
        .rise  (rise),
        .fall  (fall)
    );

    // Loads happen on the fall inside the last bit of the previous word,
    // so the shifter picks the word up one SCLK after the LRCLK edge.
    assign left_ld  = fall && (bit_cnt == CNT_BITS'(LOAD_LEFT_IDX));
    assign right_ld = fall && (bit_cnt == CNT_BITS'(LOAD_RIGHT_IDX));

    assign sample_ready = left_ld && sample_valid;
    assign LRCLK        = slot;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bit_cnt  <= CNT_BITS'(62);
            slot     <= SLOT_RIGHT;
            LD       <= 1'b0;
            Dout     <= '0;
            rbuf     <= '0;
            underrun <= 1'b0;
        end else begin
            if (rise) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (left_ld) begin
                slot <= SLOT_LEFT;
                LD   <= 1'b1;
                if (sample_valid) begin
                    Dout <= sample_left;
                    rbuf <= sample_right;
                end else begin
                    Dout <= '0;
                    rbuf <= '0;
                end
            end else if (right_ld) begin
                slot <= SLOT_RIGHT;
                LD   <= 1'b1;
                Dout <= rbuf;
            end else if (fall) begin
                LD   <= 1'b0;
            end
            // A new underrun wins over a simultaneous clear.
            if (left_ld && !sample_valid) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Directed bench for i2s_frame_ctrl: CLK_DIV=2 for framing checks,
// plus a CLK_DIV=255 instance for divider/frame-length timing.
module tb_i2s_frame_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        sample_valid;
    logic [31:0] sample_left;
    logic [31:0] sample_right;
    logic        underrun_clr;

    logic        sample_ready, SCLK, LRCLK, LD, underrun;
    logic [31:0] Dout;
    logic        rdy2, sclk2, lr2, ld2, ur2;
    logic [31:0] dout2;

    logic [31:0] sh = '0;
    logic        s;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] WA = 32'hA5A5_0001;
    localparam logic [31:0] WB = 32'h5A5A_0002;
    localparam logic [31:0] WC = 32'h1234_5678;
    localparam logic [31:0] WD = 32'h9ABC_DEF0;

    i2s_frame_ctrl #(.CLK_DIV(2)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .sample_valid (sample_valid),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_ready (sample_ready),
        .SCLK         (SCLK),
        .LRCLK        (LRCLK),
        .LD           (LD),
        .Dout         (Dout),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    i2s_frame_ctrl #(.CLK_DIV(255)) dut2 (
        .Clk          (Clk),
        .Reset        (Reset),
        .sample_valid (sample_valid),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_ready (rdy2),
        .SCLK         (sclk2),
        .LRCLK        (lr2),
        .LD           (ld2),
        .Dout         (dout2),
        .underrun     (ur2),
        .underrun_clr (underrun_clr)
    );

    always #5 Clk = ~Clk;

    // Reference model of the downstream parallel-load shifter.
    always @(posedge SCLK) sh <= LD ? Dout : {sh[30:0], 1'b0};
    assign s = sh[31];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_lr_fall(output int n);
        logic prev;
        n = 0;
        prev = lr2;
        while (n < 40000) begin
            step(1);
            n++;
            if (prev && !lr2) break;
            prev = lr2;
        end
    endtask

    initial begin
        logic [31:0] word;
        int nr, nld, nlr, n;

        Reset = 1'b1;
        sample_valid = 1'b0;
        sample_left = '0;
        sample_right = '0;
        underrun_clr = 1'b0;
        step(3);
        chk("rst_sclk", 32'(SCLK), 32'd0);
        chk("rst_lrclk", 32'(LRCLK), 32'd1);
        chk("rst_ld", 32'(LD), 32'd0);
        chk("rst_dout", Dout, 32'd0);
        chk("rst_ready", 32'(sample_ready), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);

        sample_valid = 1'b1;
        sample_left = WA;
        sample_right = WB;
        Reset = 1'b0;
        step(1);
        chk("e1_ready", 32'(sample_ready), 32'd0);
        chk("e1_ld", 32'(LD), 32'd0);
        step(2);
        chk("e3_ready", 32'(sample_ready), 32'd1);
        chk("e3_lrclk", 32'(LRCLK), 32'd1);
        step(1);
        chk("e4_ld", 32'(LD), 32'd1);
        chk("e4_lrclk", 32'(LRCLK), 32'd0);
        chk("e4_dout", Dout, WA);
        chk("e4_ready", 32'(sample_ready), 32'd0);
        step(2);
        chk("e6_sclk", 32'(SCLK), 32'd1);

        word = '0;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) step(4);
            word = {word[30:0], s};
        end
        chk("left_lsb_lrclk", 32'(LRCLK), 32'd0);
        chk("left_word", word, WA);
        step(4);
        chk("right_msb_lrclk", 32'(LRCLK), 32'd1);
        word = '0;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) step(4);
            word = {word[30:0], s};
        end
        chk("right_word", word, WB);

        nr = 0;
        nld = 0;
        nlr = 0;
        for (int i = 0; i < 1024; i++) begin
            nr += int'(sample_ready);
            nld += int'(LD);
            nlr += int'(LRCLK);
            step(1);
        end
        chk("stream_ready", 32'(nr), 32'd4);
        chk("stream_ld", 32'(nld), 32'd32);
        chk("stream_lrclk_hi", 32'(nlr), 32'd512);
        chk("stream_underrun", 32'(underrun), 32'd0);

        sample_valid = 1'b0;
        step(1);
        chk("ur_ready", 32'(sample_ready), 32'd0);
        step(1);
        chk("ur_ld", 32'(LD), 32'd1);
        chk("ur_left_dout", Dout, 32'd0);
        chk("ur_flag", 32'(underrun), 32'd1);
        step(128);
        chk("ur_right_ld", 32'(LD), 32'd1);
        chk("ur_right_lrclk", 32'(LRCLK), 32'd1);
        chk("ur_right_dout", Dout, 32'd0);
        step(127);
        underrun_clr = 1'b1;
        step(1);
        chk("ur_set_beats_clr", 32'(underrun), 32'd1);
        underrun_clr = 1'b0;
        sample_valid = 1'b1;
        sample_left = WC;
        sample_right = WD;
        step(255);
        chk("clean_ready", 32'(sample_ready), 32'd1);
        step(1);
        chk("clean_dout", Dout, WC);
        chk("clean_ur_held", 32'(underrun), 32'd1);
        underrun_clr = 1'b1;
        step(1);
        underrun_clr = 1'b0;
        chk("ur_cleared", 32'(underrun), 32'd0);

        sample_valid = 1'b0;
        for (int i = 0; i < 126; i++) begin
            sample_left = $urandom;
            chk("idle_ready", 32'(sample_ready), 32'd0);
            step(1);
            chk("idle_dout", Dout, WC);
        end
        step(1);
        chk("idle_right_dout", Dout, WD);
        chk("idle_right_ld", 32'(LD), 32'd1);

        step(34);
        Reset = 1'b1;
        step(1);
        chk("mid_rst_sclk", 32'(SCLK), 32'd0);
        chk("mid_rst_lrclk", 32'(LRCLK), 32'd1);
        chk("mid_rst_ld", 32'(LD), 32'd0);
        chk("mid_rst_dout", Dout, 32'd0);
        chk("mid_rst_ready", 32'(sample_ready), 32'd0);
        sample_valid = 1'b1;
        sample_left = WA;
        sample_right = WB;
        Reset = 1'b0;
        step(3);
        chk("resync_ready", 32'(sample_ready), 32'd1);
        chk("resync_ld_early", 32'(LD), 32'd0);
        step(1);
        chk("resync_ld", 32'(LD), 32'd1);
        chk("resync_dout", Dout, WA);
        chk("resync_lrclk", 32'(LRCLK), 32'd0);

        n = 0;
        while (!sclk2 && n < 2000) begin
            step(1);
            n++;
        end
        chk("div255_rise_seen", 32'(n < 2000), 32'd1);
        n = 0;
        while (sclk2 && n < 2000) begin
            step(1);
            n++;
        end
        chk("div255_half", 32'(n), 32'd255);
        wait_lr_fall(n);
        chk("div255_lr_seen", 32'(n < 40000), 32'd1);
        wait_lr_fall(n);
        chk("div255_frame", 32'(n), 32'd32640);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
